drop_sequencer: RTL and testbench
=================================

DROP_SEQUENCER -- requirements
Module: drop_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of t_act and t_lim; a multiple of 4, range 8..32.
REQ-002 SHALL have parameter N_DIGITS, default 4: number of seven-segment digits; range 4..8.
REQ-003 SHALL have parameter CONFIRM_CYCLES, default 3: consecutive qualifying clock edges required before a drop; minimum 2.
REQ-004 SHALL have parameter DROP_CYCLES, default 4: number of cycles drop_activated is held high; minimum 1.
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 6: number of dead cycles after a drop; minimum 1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port t_act, input, DATA_WIDTH bits: actual time, unsigned.
REQ-009 SHALL have port t_lim, input, DATA_WIDTH bits: limit time, unsigned.
REQ-010 SHALL have port drop_en, input, 1 bit: drop enable.
REQ-011 SHALL have port abort, input, 1 bit: cancel request.
REQ-012 SHALL have port seven_seg, output, 7*N_DIGITS bits: digit i occupies [7i+6:7i]; digit 0 is rightmost; bit 6=g down to bit 0=a; segments active-high.
REQ-013 SHALL have port drop_activated, output, 1 bit: drop actuator command.
REQ-014 SHALL have port state, output, 2 bits: IDLE=0, CONFIRM=1, DROP=2, LOCKOUT=3.

Function
REQ-015 SHALL define "qualify" as drop_en=1 and t_act<=t_lim (unsigned), sampled at the clock edge.
REQ-016 In IDLE, a qualifying edge SHALL move to CONFIRM with the confirm count set to 1; any other edge SHALL remain in IDLE.
REQ-017 In CONFIRM, a non-qualifying edge or abort=1 SHALL return to IDLE.
REQ-018 In CONFIRM, a qualifying edge SHALL move to DROP when the count equals CONFIRM_CYCLES-1, and SHALL otherwise increment the count.
REQ-019 DROP SHALL last exactly DROP_CYCLES cycles, then move to LOCKOUT; abort=1 in DROP SHALL move to LOCKOUT at that edge.
REQ-020 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then move to IDLE; abort and inputs SHALL be ignored in LOCKOUT.
REQ-021 abort SHALL have no effect in IDLE.
REQ-022 drop_activated SHALL be registered and equal 1 exactly in the cycles when state=DROP.
REQ-023 seven_seg SHALL be registered; after each edge it SHALL reflect the state entered at that edge and the t_act sampled at that edge.
REQ-024 In IDLE and CONFIRM, digit i SHALL show hex nibble i of t_act; nibbles at or above DATA_WIDTH/4 SHALL show 0.
REQ-025 Hex glyph codes SHALL be 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-026 In DROP, digits 3..0 SHALL show d=5E, r=50, o=5C, P=73, and digits above 3 SHALL be blank (00).
REQ-027 In LOCKOUT, all digits SHALL show dash (40).
REQ-028 The duration counter SHALL be wide enough for the largest of CONFIRM_CYCLES, DROP_CYCLES and LOCKOUT_CYCLES, and SHALL be cleared on every state change.

Reset
REQ-029 While rst_n=0, the outputs SHALL immediately be state=IDLE, counter=0, drop_activated=0 and all seven_seg digits 00, independent of clk.
REQ-030 Reset asserted mid-DROP SHALL drop drop_activated immediately, and after release the block SHALL start in IDLE with no lockout.

Verification (defaults; seven_seg listed as digits 3..0)
REQ-031 Reset: rst_n=0 -> state=0, drop_activated=0, seven_seg=00 00 00 00; after release with t_act=0x0123 and drop_en=0, one edge -> 3F 06 5B 4F.
REQ-032 Normal drop: t_act=0x0123, t_lim=0x0200, drop_en=1 held from edge 1 -> CONFIRM after edge 1; DROP after edge 3 with drop_activated=1 for 4 cycles and seven_seg=5E 50 5C 73; LOCKOUT for 6 cycles with 40 40 40 40; IDLE; a second drop starts since the condition is still held.
REQ-033 Glitch: qualify for 2 edges, then t_act=0x0300 -> IDLE, drop_activated never asserted.
REQ-034 Boundary: t_act=t_lim=0x00FF -> qualifies and drops; t_act=0x0100 with t_lim=0x00FF -> stays IDLE; drop_en=0 -> stays IDLE.
REQ-035 Abort: abort=1 in the 2nd DROP cycle -> drop_activated=0 next cycle, full 6-cycle LOCKOUT; abort=1 in CONFIRM -> IDLE.
REQ-036 Async reset: rst_n=0 mid-clock in the 3rd DROP cycle -> drop_activated=0 and seven_seg=00 before the next edge.

Source files
------------

// File: rtl/drop_sequencer.sv
// drop_sequencer
//   Confirms a "time within limit" condition over several consecutive clock
//   edges, then pulses a drop actuator for a fixed number of cycles. After the
//   pulse comes a dead-time lockout. The current phase is shown on a row of
//   seven-segment digits.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   t_act, t_lim   actual / limit time, unsigned, DATA_WIDTH bits
//   drop_en        drop enable
//   abort          cancel request (honoured in CONFIRM and DROP only)
//   seven_seg      registered display, digit i at [7i+6:7i], active-high, bit 6 = g
//   drop_activated registered actuator command, high exactly while state = DROP
//   state          registered FSM state: IDLE=0, CONFIRM=1, DROP=2, LOCKOUT=3
//
// Handshake note: this block has no valid/ready channels. Inputs are plain
// levels that are sampled on every rising clock edge.
module drop_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int N_DIGITS       = 4,
  parameter int CONFIRM_CYCLES = 3,
  parameter int DROP_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   t_act,
  input  logic [DATA_WIDTH-1:0]   t_lim,
  input  logic                    drop_en,
  input  logic                    abort,
  output logic [7*N_DIGITS-1:0]   seven_seg,
  output logic                    drop_activated,
  output logic [1:0]              state
);

  localparam int MAX_CD  = (CONFIRM_CYCLES > DROP_CYCLES) ? CONFIRM_CYCLES : DROP_CYCLES;
  localparam int MAX_CYC = (MAX_CD > LOCKOUT_CYCLES) ? MAX_CD : LOCKOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DISP_W  = 4 * N_DIGITS;

  // The counter holds how many edges have already been spent in the current
  // state, so each state exits when it reaches its cycle count minus one.
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST    = CNT_W'(DROP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_DROP    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7*N_DIGITS-1:0] seg_d;
  logic               drop_d;
  logic               qualify;
  // t_act zero-extended (or truncated) to one nibble per digit, so digits
  // beyond the data width show 0.
  logic [DISP_W-1:0]  t_disp;

  assign qualify = drop_en && (t_act <= t_lim);
  assign t_disp  = DISP_W'(t_act);
  assign state   = state_q;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Next-state and duration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // The qualifying edge that leaves IDLE already counts as one.
        if (qualify) begin
          state_d = ST_CONFIRM;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (!qualify || abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CONFIRM_LAST) begin
          state_d = ST_DROP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DROP: begin
        if (abort || (cnt_q == DROP_LAST)) begin
          state_d = ST_LOCKOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        // Dead time: inputs and abort are deliberately ignored here.
        if (cnt_q == LOCKOUT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the state being entered, then registered, so
  // they line up with state_q after each edge.
  always_comb begin
    seg_d  = '0;
    drop_d = (state_d == ST_DROP);
    unique case (state_d)
      ST_IDLE, ST_CONFIRM: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          seg_d[7*i +: 7] = hex_glyph(t_disp[4*i +: 4]);
        end
      end
      ST_DROP: begin
        // "droP" on digits 3..0; higher digits stay blank.
        seg_d[27:0] = {7'h5E, 7'h50, 7'h5C, 7'h73};
      end
      ST_LOCKOUT: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          seg_d[7*i +: 7] = 7'h40;
        end
      end
      default: seg_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      seven_seg      <= '0;
      drop_activated <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seven_seg      <= seg_d;
      drop_activated <= drop_d;
    end
  end

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer (default parameters). A phase /
// streak / remaining-cycles reference model predicts state, drop_activated
// and seven_seg after every edge; predictions go through exp_q.
module tb_drop_sequencer;

  localparam int DATA_WIDTH     = 16;
  localparam int N_DIGITS       = 4;
  localparam int CONFIRM_CYCLES = 3;
  localparam int DROP_CYCLES    = 4;
  localparam int LOCKOUT_CYCLES = 6;
  localparam int SEG_W          = 7 * N_DIGITS;
  localparam int W              = 3 + SEG_W;

  localparam int M_IDLE    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_DROP    = 2;
  localparam int M_LOCK    = 3;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [DATA_WIDTH-1:0] t_act = '0;
  logic [DATA_WIDTH-1:0] t_lim = '0;
  logic                  drop_en = 1'b0;
  logic                  abort = 1'b0;
  logic [SEG_W-1:0]      seven_seg;
  logic                  drop_activated;
  logic [1:0]            state;

  always #5 clk = ~clk;

  drop_sequencer #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_DIGITS(N_DIGITS),
    .CONFIRM_CYCLES(CONFIRM_CYCLES),
    .DROP_CYCLES(DROP_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .t_act(t_act),
    .t_lim(t_lim),
    .drop_en(drop_en),
    .abort(abort),
    .seven_seg(seven_seg),
    .drop_activated(drop_activated),
    .state(state)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  int m_mode   = M_IDLE;
  int m_streak = 0;
  int m_remain = 0;

  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // "droP" indexed by digit number 0..3
  logic [6:0] drop_g [0:3] = '{7'h73, 7'h5C, 7'h50, 7'h5E};

  function automatic logic [SEG_W-1:0] exp_seg(input int mode, input logic [DATA_WIDTH-1:0] act);
    logic [SEG_W-1:0]      s;
    logic [DATA_WIDTH-1:0] sh;
    int                    nib;
    s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (mode == M_IDLE || mode == M_CONFIRM) begin
        sh  = act >> (4 * i);
        nib = (i < DATA_WIDTH / 4) ? int'(sh[3:0]) : 0;
        s[7*i +: 7] = glyph[nib];
      end else if (mode == M_DROP) begin
        if (i < 4) s[7*i +: 7] = drop_g[i];
      end else begin
        s[7*i +: 7] = 7'h40;
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_streak = 0;
    m_remain = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] lim,
                            input logic en, input logic ab);
    logic       q;
    logic [1:0] ms;
    q = en && (act <= lim);
    case (m_mode)
      M_IDLE: begin
        if (q) begin m_mode = M_CONFIRM; m_streak = 1; end
      end
      M_CONFIRM: begin
        if (!q || ab) begin
          m_mode = M_IDLE; m_streak = 0;
        end else begin
          m_streak++;
          if (m_streak == CONFIRM_CYCLES) begin m_mode = M_DROP; m_remain = DROP_CYCLES; end
        end
      end
      M_DROP: begin
        m_remain--;
        if (ab || m_remain == 0) begin m_mode = M_LOCK; m_remain = LOCKOUT_CYCLES; end
      end
      default: begin
        m_remain--;
        if (m_remain == 0) m_mode = M_IDLE;
      end
    endcase
    ms = m_mode[1:0];
    exp_q.push_back({ms, (m_mode == M_DROP), exp_seg(m_mode, act)});
  endtask

  // ---------------- driver ----------------
  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic step(input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] lim,
                      input logic en, input logic ab);
    t_act   = act;
    t_lim   = lim;
    drop_en = en;
    abort   = ab;
    @(posedge clk);
    model_step(act, lim, en, ab);
    #1;
  endtask

  // Idle the inputs long enough to leave any drop/lockout; predictions discarded.
  task automatic drain();
    logic [W-1:0] e;
    for (int k = 0; k < DROP_CYCLES + LOCKOUT_CYCLES + 2; k++) begin
      step(16'h0000, 16'h0000, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    t_act = 16'h0123; t_lim = 16'h0200; drop_en = 1'b1; abort = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({state, drop_activated, seven_seg} !== '0) $display("FAIL reset_async: got %h want 0", {state, drop_activated, seven_seg});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({state, drop_activated, seven_seg} !== '0) $display("FAIL reset_held: got %h want 0", {state, drop_activated, seven_seg});
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    step(16'h0123, 16'h0200, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if ({state, drop_activated, seven_seg} !== e) $display("FAIL reset_first_edge: got %h want %h", {state, drop_activated, seven_seg}, e);
    else n_pass++;
    n_total++;
    if (seven_seg !== {7'h3F, 7'h06, 7'h5B, 7'h4F}) $display("FAIL reset_digits: got %h want %h", seven_seg, {7'h3F, 7'h06, 7'h5B, 7'h4F});
    else n_pass++;
  endtask

  task automatic test_normal_drop();
    logic [W-1:0] e;
    int drops;
    drops = 0;
    for (int k = 1; k <= 17; k++) begin
      step(16'h0123, 16'h0200, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL normal_drop edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
      if (k <= 13 && drop_activated === 1'b1) drops++;
      if (k == 16) begin
        n_total++;
        if (state !== 2'd2) $display("FAIL normal_second_drop: got state %0d want 2", state);
        else n_pass++;
      end
    end
    n_total++;
    if (drops !== DROP_CYCLES) $display("FAIL normal_drop_len: got %0d want %0d", drops, DROP_CYCLES);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [W-1:0] e;
    logic saw_drop;
    saw_drop = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) begin
      if (k < 2) step(16'h0123, 16'h0200, 1'b1, 1'b0);
      else       step(16'h0300, 16'h0200, 1'b1, 1'b0);
      e = exp_q.pop_front();
      if (drop_activated !== 1'b0) saw_drop = 1'b1;
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL glitch edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
    end
    n_total++;
    if (saw_drop !== 1'b0 || state !== 2'd0) $display("FAIL glitch_no_drop: got drop_seen %b state %0d want 0 0", saw_drop, state);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [W-1:0] e;
    drain();
    for (int k = 1; k <= 3; k++) begin
      step(16'h00FF, 16'h00FF, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL boundary_equal edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
    end
    n_total++;
    if (drop_activated !== 1'b1) $display("FAIL boundary_equal_drops: got %b want 1", drop_activated);
    else n_pass++;
    drain();
    for (int k = 0; k < 10; k++) begin
      if (k < 5) step(16'h0100, 16'h00FF, 1'b1, 1'b0);
      else       step(16'h0010, 16'h00FF, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e || state !== 2'd0)
        $display("FAIL boundary_idle edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] e;
    int locks;
    locks = 0;
    drain();
    // edges 1-3 reach DROP, edge 4 starts the 2nd DROP cycle, abort at edge 5
    for (int k = 1; k <= 12; k++) begin
      if (k <= 4) step(16'h0123, 16'h0200, 1'b1, 1'b0);
      else        step(16'h0123, 16'h0200, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL abort_drop edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
      if (k == 5) begin
        n_total++;
        if (drop_activated !== 1'b0) $display("FAIL abort_drop_release: got %b want 0", drop_activated);
        else n_pass++;
      end
      if (k >= 5 && state === 2'd3) locks++;
    end
    n_total++;
    if (locks !== LOCKOUT_CYCLES) $display("FAIL abort_lockout_len: got %0d want %0d", locks, LOCKOUT_CYCLES);
    else n_pass++;
    // abort while confirming
    step(16'h0123, 16'h0200, 1'b1, 1'b0);
    e = exp_q.pop_front();
    step(16'h0123, 16'h0200, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_total++;
    if ({state, drop_activated, seven_seg} !== e || state !== 2'd0)
      $display("FAIL abort_confirm: got %h want %h", {state, drop_activated, seven_seg}, e);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    drain();
    for (int k = 1; k <= 5; k++) begin
      step(16'h0123, 16'h0200, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL async_setup edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
    end
    // now in the 3rd DROP cycle; pull reset between edges
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({state, drop_activated, seven_seg} !== '0) $display("FAIL async_reset_mid_drop: got %h want 0", {state, drop_activated, seven_seg});
    else n_pass++;
    #1 rst_n = 1'b1;
    model_reset();
    step(16'h0123, 16'h0200, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if ({state, drop_activated, seven_seg} !== e || state !== 2'd1)
      $display("FAIL async_restart: got %h want %h", {state, drop_activated, seven_seg}, e);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [DATA_WIDTH-1:0] a, l;
    logic en, ab;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = DATA_WIDTH'($urandom_range(0, 16'hFFFF));
        l = DATA_WIDTH'($urandom_range(0, 16'hFFFF));
      end else begin
        a = DATA_WIDTH'($urandom_range(0, 255));
        l = DATA_WIDTH'($urandom_range(0, 300));
      end
      en = ($urandom_range(0, 7) != 0);
      ab = ($urandom_range(0, 9) == 0);
      step(a, l, en, ab);
      e = exp_q.pop_front();
      n_total++;
      if ({state, drop_activated, seven_seg} !== e) $display("FAIL random edge %0d: got %h want %h", k, {state, drop_activated, seven_seg}, e);
      else n_pass++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_normal_drop();
    test_glitch();
    test_boundary();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
